// File: rtl/kernel_window_feeder.sv
// Streaming 3x3 window generator over a raster pixel stream with two line buffers.
// Optional per-frame window counter enabled by defining KFEED_WIN_COUNT_EN.
module kernel_window_feeder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  ksel_in,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [23:0] cache_out [0:2],
    output logic [1:0]  ksel_out,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] win_count
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [7:0]    lb0_r [0:IMG_W-1];
    logic [7:0]    lb1_r [0:IMG_W-1];
    logic [15:0]   top_sh_r;
    logic [15:0]   mid_sh_r;
    logic [15:0]   bot_sh_r;
    logic [7:0]    lb_top_s;
    logic [7:0]    lb_mid_s;
    logic          accept_s;
    logic          start_acc_s;
    logic          last_pix_s;
    logic          load_s;

    assign lb_top_s    = lb0_r[col_r];
    assign lb_mid_s    = lb1_r[col_r];
    assign accept_s    = pix_valid && pix_ready;
    assign start_acc_s = (state_r == S_IDLE) && start;
    assign last_pix_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);
    assign load_s      = accept_s && (row_r >= RW'(2)) && (col_r >= CW'(2));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nx_s = S_RUN;
                else       state_nx_s = S_IDLE;
            end
            S_RUN: begin
                if (accept_s && last_pix_s) state_nx_s = S_FLUSH;
                else                        state_nx_s = S_RUN;
            end
            S_FLUSH: begin
                if (!win_valid || win_ready) state_nx_s = S_DONE;
                else                         state_nx_s = S_FLUSH;
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State-decoded outputs; pixel intake stalls whenever a held window is not being taken
    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            S_RUN: begin
                pix_ready = !win_valid || win_ready;
                busy      = 1'b1;
            end
            S_FLUSH: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                pix_ready = 1'b0;
                busy      = 1'b0;
                done      = 1'b0;
            end
        endcase
    end

    // Line buffers hold the two previous lines; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= pix_in;
        end
    end

    // Position counters, column shift registers, window output register and select latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r        <= '0;
            col_r        <= '0;
            top_sh_r     <= 16'h0000;
            mid_sh_r     <= 16'h0000;
            bot_sh_r     <= 16'h0000;
            cache_out[0] <= 24'h000000;
            cache_out[1] <= 24'h000000;
            cache_out[2] <= 24'h000000;
            ksel_out     <= 2'b00;
            win_valid    <= 1'b0;
        end else begin
            if (start_acc_s) begin
                ksel_out <= ksel_in;
                row_r    <= '0;
                col_r    <= '0;
            end else if (accept_s) begin
                if (col_r == COL_LAST) begin
                    col_r <= '0;
                    row_r <= row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end

            if (accept_s) begin
                top_sh_r <= {top_sh_r[7:0], lb_top_s};
                mid_sh_r <= {mid_sh_r[7:0], lb_mid_s};
                bot_sh_r <= {bot_sh_r[7:0], pix_in};
            end

            if (load_s) begin
                cache_out[0] <= {top_sh_r, lb_top_s};
                cache_out[1] <= {mid_sh_r, lb_mid_s};
                cache_out[2] <= {bot_sh_r, pix_in};
                win_valid    <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef KFEED_WIN_COUNT_EN
    logic [15:0] win_count_r;

    // Saturating count of windows loaded in the current frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count_r <= 16'h0000;
        end else if (start_acc_s) begin
            win_count_r <= 16'h0000;
        end else if (load_s && (win_count_r != 16'hFFFF)) begin
            win_count_r <= win_count_r + 16'h0001;
        end
    end

    assign win_count = win_count_r;
`else
    assign win_count = 16'h0000;
`endif

endmodule

// File: doc/kernel_window_feeder.md
# kernel_window_feeder

Streaming 3x3 window generator that drives the convolution Kernel stage in EXE. It accepts a raster-order 8-bit pixel stream and buffers the two previous image lines. For every interior pixel position it emits one registered 3x3 window in the Kernel's `cache_in` format (three 24-bit rows), together with the kernel select latched at frame start. A valid/ready handshake on the output lets the Kernel stage, or the writeback stage behind it, stall the feeder.

## Interface
- `IMG_W`, 64: pixels per line; must be ≥3.
- `IMG_H`, 64: lines per frame; must be ≥3.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a frame; honoured only in IDLE.
- `ksel_in` in 2: kernel select, sampled on an accepted `start`.
- `pix_in` in 8: input pixel.
- `pix_valid` in 1: `pix_in` is valid.
- `pix_ready` out 1: feeder accepts `pix_in` this cycle.
- `cache_out[0:2]` out 24 each: window rows, top to bottom; bits [23:16] left, [15:8] centre column, [7:0] right.
- `ksel_out` out 2: latched kernel select, stable for the whole frame.
- `win_valid` out 1: `cache_out` holds a window.
- `win_ready` in 1: downstream consumes the window.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: one-cycle pulse at frame completion.
- `win_count` out 16: windows issued this frame (see Configuration).

## Operation
- States:
  - IDLE → RUN on `start`. On that transition, latch `ksel_in` into `ksel_out` and clear `row`, `col` and `win_count`.
  - RUN → FLUSH when the pixel at (`IMG_H`-1, `IMG_W`-1) is accepted.
  - FLUSH → DONE once `win_valid` is low, or is being consumed this cycle.
  - DONE → IDLE after one cycle, with `done`=1 in DONE.
- `pix_ready` = (state==RUN) && (!`win_valid` || `win_ready`). Pixels offered outside RUN are ignored.
- On each accepted pixel P(r,c):
  - The column shift registers take `lb0[c]`, `lb1[c]` and `pix_in`.
  - `lb0[c]` ← `lb1[c]`; `lb1[c]` ← `pix_in`.
  - `col` increments; at `IMG_W`-1 it wraps to 0 and `row` increments.
- A window is emitted only when r≥2 and c≥2. The emitted window is:
  - `cache_out[0]` = {P(r-2,c-2), P(r-2,c-1), P(r-2,c)}
  - `cache_out[1]` = {P(r-1,c-2), P(r-1,c-1), P(r-1,c)}
  - `cache_out[2]` = {P(r,c-2), P(r,c-1), P(r,c)}
  - The centre pixel is P(r-1,c-1).
- Windows per frame: (`IMG_W`-2)·(`IMG_H`-2). No border padding.
- Accepted pixels with r<2 or c<2 only fill the buffers and leave `win_valid` unchanged. A held window remains until it is consumed.
- `win_valid` clears on `win_ready` when no new window is loaded in the same cycle. If a window is consumed and a new one is loaded in the same cycle, `win_valid` stays 1 and the data updates.
- `start` while `busy` is ignored. `ksel_in` changes during a frame have no effect.
- Line buffer contents are not reset; they are don't-care until overwritten.

## Timing
- Reset (async assert) values:
  - state=IDLE.
  - `pix_ready`=0, `win_valid`=0, `busy`=0, `done`=0.
  - `cache_out[0..2]`=24'h0, `ksel_out`=2'b00, `win_count`=0.
  - `row`=0, `col`=0.
- Reset asserted mid-frame aborts the frame immediately. No `done` is produced. The next frame requires a new `start`.
- Latency: a pixel accepted at edge N produces `win_valid`=1 and new `cache_out` after edge N, i.e. one cycle.
- Throughput: one pixel per cycle while `win_ready` is held high.
- `start` at edge N: `pix_ready` may first be high in cycle N+1.
- `done` is high for exactly one cycle, at least one cycle after the last window handshake. `busy` is low in the `done` cycle.
- Outputs are stable while `win_valid`=1 and `win_ready`=0.

## Configuration
- `KFEED_WIN_COUNT_EN`:
  - Defined: `win_count` increments on each window load, saturates at 16'hFFFF, clears on an accepted `start`, and holds its value after `done`.
  - Undefined: no counter is built and `win_count` is tied to 16'h0000.

## Test plan
- Uniform frame, `IMG_W`=`IMG_H`=4, all pixels 8'd11, `win_ready`=1 → exactly 4 windows, every row {8'd11,8'd11,8'd11}, then one `done` pulse.
- Ramp frame, 4x4, P(r,c)=4r+c:
  - First window: `cache_out[0]`={0,1,2}, `cache_out[1]`={4,5,6}, `cache_out[2]`={8,9,10}.
  - Last window: {5,6,7}, {9,10,11}, {13,14,15}.
- Backpressure: hold `win_ready`=0 for 5 cycles after the first window → `pix_ready`=0 and `cache_out` unchanged for those cycles; no pixel or window is lost once released.
- Select latch: `start` with `ksel_in`=2'b10, then drive `ksel_in`=2'b01 mid-frame → `ksel_out`=2'b10 on every window.
- Reset mid-frame: assert `rst` after 6 pixels → all outputs take their reset values at once. A new `start` and a full 4x4 ramp frame then produce the 4 correct windows.
- With `KFEED_WIN_COUNT_EN` defined: 5x4 frame → `win_count`=6 after `done`, and 0 after the next `start`. Without the macro, `win_count`=0 throughout.
